// File: rtl/cfg_loader.sv
// Serial configuration loader: hunts for a sync word, streams the payload into the
// fabric shift chain, then verifies a ones-count checksum before enabling user logic.
module cfg_loader #(
  parameter int unsigned CHAIN_LEN = 144,
  parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic cfg_start,
  input  logic cfg_din,
  input  logic cfg_valid,
  output logic cfg_ready,
  output logic shift_en,
  output logic shift_bit,
  output logic cfg_done,
  output logic cfg_err,
  output logic fabric_en
);

  localparam int unsigned CNT_W      = 12;
  localparam int unsigned SYNC_W     = 8;
  localparam int unsigned HIST_W     = SYNC_W - 1;
  localparam int unsigned CSUM_W     = 8;
  localparam int unsigned CHK_W      = 3;
  localparam int unsigned SYNC_LIMIT = 255;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LOAD, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e             state_q, state_d;
  // Only the previous seven bits are kept; the eighth is always the bit being accepted.
  logic [HIST_W-1:0]  sync_q, sync_d;
  logic [SYNC_W-1:0]  sync_cnt_q, sync_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CSUM_W-1:0]  csum_q, csum_d;
  logic [HIST_W-1:0]  rx_q, rx_d;
  logic [CHK_W-1:0]   chk_cnt_q, chk_cnt_d;
  logic               shift_en_q, shift_en_d;
  logic               shift_bit_q, shift_bit_d;

  logic               accept_c;
  logic [SYNC_W-1:0]  sync_word_c;
  logic [CSUM_W-1:0]  rx_word_c;
  logic               last_bit_c;

  assign accept_c    = cfg_valid && cfg_ready && !cfg_start;
  assign sync_word_c = {sync_q, cfg_din};
  assign rx_word_c   = {rx_q, cfg_din};
  assign last_bit_c  = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a start pulse restarts the hunt from any state
  always_comb begin
    state_d = state_q;
    if (cfg_start) begin
      state_d = S_SYNC;
    end else begin
      case (state_q)
        S_SYNC: begin
          if (accept_c) begin
            if (sync_word_c == SYNC_WORD)                       state_d = S_LOAD;
            else if (sync_cnt_q == SYNC_W'(SYNC_LIMIT - 1))     state_d = S_ERROR;
          end
        end
        S_LOAD: begin
          if (accept_c && last_bit_c) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (accept_c && (chk_cnt_q == CHK_W'(7)))
            state_d = (rx_word_c == csum_q) ? S_DONE : S_ERROR;
        end
        S_IDLE, S_DONE, S_ERROR: state_d = state_q;
        default:                 state_d = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    cfg_ready = 1'b0;
    cfg_done  = 1'b0;
    cfg_err   = 1'b0;
    fabric_en = 1'b0;
    shift_en  = shift_en_q;
    shift_bit = shift_bit_q;
    case (state_q)
      S_SYNC, S_LOAD, S_CHECK: cfg_ready = 1'b1;
      S_DONE: begin
        cfg_done  = 1'b1;
        fabric_en = 1'b1;
      end
      S_ERROR: cfg_err = 1'b1;
      default: cfg_ready = 1'b0;
    endcase
  end

  // Datapath next-state: sync hunt, payload count/checksum, received checksum
  always_comb begin
    sync_d      = sync_q;
    sync_cnt_d  = sync_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    csum_d      = csum_q;
    rx_d        = rx_q;
    chk_cnt_d   = chk_cnt_q;
    shift_en_d  = 1'b0;
    shift_bit_d = shift_bit_q;
    if (cfg_start) begin
      sync_d     = '0;
      sync_cnt_d = '0;
      bit_cnt_d  = '0;
      csum_d     = '0;
      rx_d       = '0;
      chk_cnt_d  = '0;
    end else if (accept_c) begin
      case (state_q)
        S_SYNC: begin
          sync_d     = sync_word_c[HIST_W-1:0];
          sync_cnt_d = sync_cnt_q + SYNC_W'(1);
        end
        S_LOAD: begin
          shift_en_d  = 1'b1;
          shift_bit_d = cfg_din;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          csum_d      = csum_q + CSUM_W'(cfg_din);
        end
        S_CHECK: begin
          rx_d      = rx_word_c[HIST_W-1:0];
          chk_cnt_d = chk_cnt_q + CHK_W'(1);
        end
        default: shift_en_d = 1'b0;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q      <= '0;
      sync_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      csum_q      <= '0;
      rx_q        <= '0;
      chk_cnt_q   <= '0;
      shift_en_q  <= 1'b0;
      shift_bit_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sync_cnt_q  <= sync_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      csum_q      <= csum_d;
      rx_q        <= rx_d;
      chk_cnt_q   <= chk_cnt_d;
      shift_en_q  <= shift_en_d;
      shift_bit_q <= shift_bit_d;
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: directed and randomized bitstreams checked against a
// stream-level model of sync search, payload extraction and checksum verdict.
module tb_cfg_loader;

  localparam int unsigned CHAIN_LEN = 16;
  localparam logic [7:0]  SYNC_WORD = 8'hA5;

  logic clk = 1'b0;
  logic reset, cfg_start, cfg_din, cfg_valid;
  logic cfg_ready, shift_en, shift_bit, cfg_done, cfg_err, fabric_en;

  always #5 clk = ~clk;

  cfg_loader #(.CHAIN_LEN(CHAIN_LEN), .SYNC_WORD(SYNC_WORD)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_din(cfg_din),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .shift_en(shift_en),
    .shift_bit(shift_bit), .cfg_done(cfg_done), .cfg_err(cfg_err), .fabric_en(fabric_en)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt  = 0;
  bit shq[$];
  int shidx[$];
  bit stim[$];

  typedef struct {
    int          sync_end;   // bits consumed through the sync word, 0 if never found
    int          outcome;    // 0 incomplete, 1 done, 2 error
    logic [15:0] payload;
  } exp_t;

  // Record every shift pulse with the 1-based index of the accepted bit that caused it
  always @(posedge clk) begin
    if (reset && cfg_valid && cfg_ready && !cfg_start) acc_cnt++;
    #1;
    if (shift_en) begin
      shq.push_back(shift_bit);
      shidx.push_back(acc_cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stream-level model: the last eight bits seen form the sync window
  function automatic exp_t model_expect();
    exp_t e;
    logic [7:0] win = '0;
    logic [7:0] rx  = '0;
    int ones = 0;
    e.sync_end = 0; e.outcome = 0; e.payload = '0;
    for (int i = 0; i < stim.size(); i++) begin
      win = {win[6:0], stim[i]};
      if (win == SYNC_WORD) begin
        e.sync_end = i + 1;
        break;
      end
      if (i + 1 == 255) begin
        e.outcome = 2;
        return e;
      end
    end
    if (e.sync_end == 0 || stim.size() < e.sync_end + CHAIN_LEN + 8) return e;
    for (int p = 0; p < CHAIN_LEN; p++) begin
      e.payload = {e.payload[14:0], stim[e.sync_end + p]};
      ones += int'(stim[e.sync_end + p]);
    end
    for (int k = 0; k < 8; k++) rx = {rx[6:0], stim[e.sync_end + CHAIN_LEN + k]};
    e.outcome = (rx == 8'(ones % 256)) ? 1 : 2;
    return e;
  endfunction

  function automatic logic [15:0] packed_shifts();
    logic [15:0] v = '0;
    foreach (shq[i]) v = {v[14:0], shq[i]};
    return v;
  endfunction

  task automatic add_field(input logic [15:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) stim.push_back(v[i]);
  endtask

  task automatic clear_monitor();
    acc_cnt = 0;
    shq.delete();
    shidx.delete();
  endtask

  task automatic do_start();
    @(negedge clk);
    cfg_start = 1'b1; cfg_valid = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    clear_monitor();
  endtask

  // gap_mode: 0 continuous, 1 idle cycle before every bit, 2 random 0..2 idle cycles
  task automatic send_stream(input int gap_mode, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int gaps;
      gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        cfg_valid = 1'b0; cfg_din = 1'($urandom);
      end
      @(negedge clk);
      cfg_valid = 1'b1; cfg_din = stim[i];
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_start = 1'b1; cfg_valid = 1'b1; cfg_din = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", cfg_ready); else n_pass++;
    n_checks++; if (cfg_done !== 1'b0) $display("FAIL reset_done_under_start: got %b expected 0", cfg_done); else n_pass++;
    reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_din = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({cfg_ready, shift_en, shift_bit} !== 3'b000)
      $display("FAIL reset_idle_a: got %b expected 000", {cfg_ready, shift_en, shift_bit}); else n_pass++;
    n_checks++; if ({cfg_done, cfg_err, fabric_en} !== 3'b000)
      $display("FAIL reset_idle_b: got %b expected 000", {cfg_done, cfg_err, fabric_en}); else n_pass++;
    // Valid bits without a start must be ignored
    clear_monitor();
    repeat (10) begin
      @(negedge clk);
      cfg_valid = 1'b1; cfg_din = 1'($urandom);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (shq.size() !== 0) $display("FAIL idle_ignore: got %0d pulses expected 0", shq.size()); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL idle_ready: got %b expected 0", cfg_ready); else n_pass++;
  endtask

  task automatic test_load(input string name, input logic [15:0] junk, input int junk_len,
                           input logic [15:0] payload, input logic [7:0] csum, input int gap_mode);
    exp_t e;
    int first_idx, last_idx;
    do_start();
    stim.delete();
    add_field(junk, junk_len);
    add_field(16'(SYNC_WORD), 8);
    add_field(payload, CHAIN_LEN);
    add_field(16'(csum), 8);
    e = model_expect();
    send_stream(gap_mode, stim.size());
    repeat (2) @(negedge clk);
    first_idx = (shidx.size() > 0) ? shidx[0] : -1;
    last_idx  = (shidx.size() > 0) ? shidx[shidx.size() - 1] : -1;
    n_checks++; if (shq.size() !== CHAIN_LEN) $display("FAIL %s_pulses: got %0d expected %0d", name, shq.size(), CHAIN_LEN); else n_pass++;
    n_checks++; if (packed_shifts() !== e.payload) $display("FAIL %s_bits: got %h expected %h", name, packed_shifts(), e.payload); else n_pass++;
    n_checks++; if (first_idx !== e.sync_end + 1) $display("FAIL %s_first_shift: got bit %0d expected %0d", name, first_idx, e.sync_end + 1); else n_pass++;
    n_checks++; if (last_idx !== e.sync_end + CHAIN_LEN) $display("FAIL %s_last_shift: got bit %0d expected %0d", name, last_idx, e.sync_end + CHAIN_LEN); else n_pass++;
    n_checks++; if (cfg_done !== (e.outcome == 1)) $display("FAIL %s_done: got %b expected %b", name, cfg_done, e.outcome == 1); else n_pass++;
    n_checks++; if (fabric_en !== (e.outcome == 1)) $display("FAIL %s_fabric: got %b expected %b", name, fabric_en, e.outcome == 1); else n_pass++;
    n_checks++; if (cfg_err !== (e.outcome == 2)) $display("FAIL %s_err: got %b expected %b", name, cfg_err, e.outcome == 2); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL %s_ready: got %b expected 0", name, cfg_ready); else n_pass++;
  endtask

  task automatic test_sync_timeout();
    do_start();
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (i == 254) begin
        n_checks++; if (cfg_err !== 1'b0) $display("FAIL timeout_early: got err %b expected 0 after 254 bits", cfg_err); else n_pass++;
        n_checks++; if (cfg_ready !== 1'b1) $display("FAIL timeout_ready254: got %b expected 1", cfg_ready); else n_pass++;
      end
      cfg_valid = 1'b1; cfg_din = 1'b0;
    end
    @(posedge clk);
    #1;
    n_checks++; if (cfg_err !== 1'b1) $display("FAIL timeout_err: got %b expected 1", cfg_err); else n_pass++;
    n_checks++; if ({cfg_done, fabric_en, cfg_ready} !== 3'b000)
      $display("FAIL timeout_flags: got %b expected 000", {cfg_done, fabric_en, cfg_ready}); else n_pass++;
    @(negedge clk);
    cfg_valid = 1'b0;
    n_checks++; if (shq.size() !== 0) $display("FAIL timeout_shifts: got %0d expected 0", shq.size()); else n_pass++;
  endtask

  task automatic test_restart();
    exp_t e;
    logic [15:0] pay;
    do_start();
    n_checks++; if ({cfg_err, cfg_done, fabric_en, cfg_ready} !== 4'b0001)
      $display("FAIL restart_clear: got %b expected 0001", {cfg_err, cfg_done, fabric_en, cfg_ready}); else n_pass++;
    stim.delete();
    add_field(16'(SYNC_WORD), 8);
    add_field(16'($urandom), CHAIN_LEN);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1; cfg_din = stim[i];
    end
    @(negedge clk);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_din = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cfg_valid = 1'b0;
    n_checks++; if (shq.size() !== 5) $display("FAIL restart_partial: got %0d pulses expected 5", shq.size()); else n_pass++;
    n_checks++; if ({shift_en, cfg_ready} !== 2'b01) $display("FAIL restart_drop: got %b expected 01", {shift_en, cfg_ready}); else n_pass++;
    clear_monitor();
    pay = 16'($urandom);
    stim.delete();
    add_field(16'(SYNC_WORD), 8);
    add_field(pay, CHAIN_LEN);
    add_field(16'($countones(pay)), 8);
    e = model_expect();
    send_stream(0, stim.size());
    repeat (2) @(negedge clk);
    n_checks++; if (shq.size() !== CHAIN_LEN) $display("FAIL restart_pulses: got %0d expected %0d", shq.size(), CHAIN_LEN); else n_pass++;
    n_checks++; if (packed_shifts() !== e.payload) $display("FAIL restart_bits: got %h expected %h", packed_shifts(), e.payload); else n_pass++;
    n_checks++; if ({cfg_done, fabric_en, cfg_err} !== 3'b110) $display("FAIL restart_done: got %b expected 110", {cfg_done, fabric_en, cfg_err}); else n_pass++;
  endtask

  task automatic test_reset_midload();
    do_start();
    stim.delete();
    add_field(16'(SYNC_WORD), 8);
    add_field(16'hFFFF, CHAIN_LEN);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1; cfg_din = stim[i];
    end
    @(negedge clk);
    reset = 1'b0; cfg_valid = 1'b1; cfg_din = 1'b1;
    @(negedge clk);
    reset = 1'b1; cfg_valid = 1'b0;
    n_checks++; if (shq.size() !== 5) $display("FAIL midreset_pulses: got %0d expected 5", shq.size()); else n_pass++;
    n_checks++; if ({cfg_ready, shift_en, shift_bit, cfg_done, cfg_err, fabric_en} !== 6'b0)
      $display("FAIL midreset_outputs: got %b expected 000000", {cfg_ready, shift_en, shift_bit, cfg_done, cfg_err, fabric_en}); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (shq.size() !== 5) $display("FAIL midreset_late_pulse: got %0d expected 5", shq.size()); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [15:0] pay;
      logic [7:0]  cs;
      pay = 16'($urandom);
      cs  = ($urandom_range(0, 1) == 1) ? 8'($countones(pay)) : 8'($urandom);
      test_load($sformatf("rand%0d", it), 16'($urandom), int'($urandom_range(0, 12)),
                pay, cs, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_load("pass", 16'h0, 0, 16'hF00F, 8'h08, 0);
    test_load("bad_csum", 16'h0, 0, 16'hF00F, 8'h07, 0);
    test_load("junk_gaps", 16'b110, 3, 16'hF00F, 8'h08, 1);
    test_sync_timeout();
    test_restart();
    test_reset_midload();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter: CHAIN_LEN, 144, number of configuration bits in the fabric shift chain (3x3 cells x 16 bits); legal range 8..4095.
REQ-002 Parameter: SYNC_WORD, 8'hA5, 8-bit pattern that precedes the payload.
REQ-003 Port: clk  input  1  single clock for all state elements.
REQ-004 Port: reset  input  1  synchronous, active-low reset sampled on rising clk.
REQ-005 Port: cfg_start  input  1  one-cycle pulse; begins or restarts a configuration load.
REQ-006 Port: cfg_din  input  1  serial bitstream data, MSB of each field first.
REQ-007 Port: cfg_valid  input  1  cfg_din is valid this cycle.
REQ-008 Port: cfg_ready  output  1  loader accepts a bit this cycle; a bit transfers when cfg_valid and cfg_ready are both high.
REQ-009 Port: shift_en  output  1  one-cycle strobe advancing the configuration chain by one bit.
REQ-010 Port: shift_bit  output  1  bit fed into the head of the chain, valid while shift_en is high.
REQ-011 Port: cfg_done  output  1  load completed with correct checksum; held until next cfg_start or reset.
REQ-012 Port: cfg_err  output  1  load failed (checksum mismatch or sync timeout); held until next cfg_start or reset.
REQ-013 Port: fabric_en  output  1  user logic enable; high only in DONE.

Function
REQ-014 States SHALL be IDLE, SYNC, LOAD, CHECK, DONE, ERROR; cfg_ready SHALL be high exactly in SYNC, LOAD, CHECK.
REQ-015 IDLE/DONE/ERROR: cfg_start SHALL enter SYNC next cycle, clearing cfg_done, cfg_err, fabric_en, all counters and the sync shift register.
REQ-016 cfg_start while in SYNC, LOAD or CHECK SHALL abort the load and re-enter SYNC with the same clearing; a bit presented in the cfg_start cycle SHALL be dropped.
REQ-017 SYNC: each accepted bit SHALL shift into an 8-bit register (new bit at LSB); when the register including the current bit equals SYNC_WORD, next state SHALL be LOAD.
REQ-018 SYNC: after 255 accepted bits without match the loader SHALL enter ERROR (cfg_err=1).
REQ-019 LOAD: each accepted bit SHALL produce shift_en=1 and shift_bit=that bit on the following cycle (registered, latency 1); shift_en SHALL be 0 in all other cycles.
REQ-020 LOAD: a 12-bit bit counter SHALL count accepted payload bits; on the CHAIN_LEN-th bit next state SHALL be CHECK.
REQ-021 LOAD: an 8-bit checksum SHALL accumulate the number of payload ones, modulo 256 (wraps 255->0).
REQ-022 CHECK: 8 accepted bits SHALL form the received checksum, MSB first; on the 8th bit, match SHALL enter DONE, mismatch SHALL enter ERROR.
REQ-023 DONE: cfg_done=1, fabric_en=1, cfg_err=0; ERROR: cfg_err=1, cfg_done=0, fabric_en=0.
REQ-024 Gaps in cfg_valid in any receiving state SHALL stall progress without timeout except per REQ-018.
REQ-025 Bits presented while cfg_ready=0 SHALL be ignored and produce no shift_en.

Reset
REQ-026 reset=0 at a rising clk SHALL force IDLE, cfg_ready=0, shift_en=0, shift_bit=0, cfg_done=0, cfg_err=0, fabric_en=0, all counters and registers to 0, overriding cfg_start.
REQ-027 reset asserted mid-LOAD SHALL abandon the load; a pending shift_en SHALL not be issued.

Verification (bench uses CHAIN_LEN=16)
REQ-028 Reset held 2 cycles then released, no stimulus -> all outputs 0, state IDLE, cfg_ready=0.
REQ-029 cfg_start, stream 0xA5, payload 0xF00F, checksum 0x08, cfg_valid continuous -> exactly 16 shift_en pulses carrying 1111000000001111 in order, then cfg_done=1, fabric_en=1, cfg_err=0.
REQ-030 Same stream with checksum 0x07 -> 16 shift_en pulses, then cfg_err=1, cfg_done=0, fabric_en=0.
REQ-031 cfg_start then 3 junk bits 110 before 0xA5, valid deasserted every other cycle -> sync found, payload loaded, cfg_done=1; no shift_en during junk or sync bits.
REQ-032 cfg_start then 255 zero bits -> cfg_err=1 on the cycle after the 255th bit, no shift_en issued.
REQ-033 Second cfg_start after 5 payload bits, then full valid stream -> flags cleared, counter restarts, cfg_done=1 after exactly 16 further shift_en pulses.
